// File: rtl/rotary_quad_decoder.sv
// Rotary encoder front end. It synchronizes and debounces the raw quadrature
// pins, decodes detents and direction, and keeps a wrapping detent count.
// r_event is a clean level that rises once per detent. r_dir settles at least
// one cycle before that rise.
module rotary_quad_decoder #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int POS_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rot_a,
    input  logic             rot_b,
    output logic             r_event,
    output logic             r_dir,
    output logic             r_step,
    output logic [POS_W-1:0] pos
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Cycles after reset before q1 reflects the real pins. The sync and
    // debounce flops reset to 0, so an encoder resting at 11 would otherwise
    // look like 00 for a while and arm the detector too early.
    localparam int SETTLE   = DEBOUNCE_CYCLES + 3;
    localparam int SETTLE_W = $clog2(SETTLE + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE);

    // Bit 0 is channel A and bit 1 is channel B.
    logic [1:0]          meta;
    logic [1:0]          sync;
    logic [1:0]          db;
    logic [CNT_W-1:0]    cnt [2];
    logic                a_db;
    logic                b_db;
    logic                q1;
    logic                q2;
    logic                q1_d;
    logic                armed;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                rise;
    logic                rise_d;

    assign a_db = db[0];
    assign b_db = db[1];
    assign rise = q1 & ~q1_d & armed;

    // Two-flop synchronizer per channel for the asynchronous pins.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= {rot_b, rot_a};
            sync <= meta;
        end
    end

    // Per-channel debounce: db flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= sync[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Quadrature decode: q1 marks the detent half (11/00), q2 the direction half (01/10).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else begin
            case ({a_db, b_db})
                2'b11:   q1 <= 1'b1;
                2'b00:   q1 <= 1'b0;
                default: q1 <= q1;
            endcase
            case ({a_db, b_db})
                2'b01:   q2 <= 1'b1;
                2'b10:   q2 <= 1'b0;
                default: q2 <= q2;
            endcase
        end
    end

    // Arming: wait for the front end to settle, then arm on the first q1 == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            if (settle_cnt != SETTLE_LAST) begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
            if (settle_cnt == SETTLE_LAST && !q1) begin
                armed <= 1'b1;
            end
        end
    end

    // Detent edge: latch direction, move the counter, then raise r_event and r_step together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_d    <= 1'b0;
            rise_d  <= 1'b0;
            r_event <= 1'b0;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            pos     <= '0;
        end else begin
            q1_d    <= q1;
            rise_d  <= rise;
            r_event <= q1_d & armed;
            r_step  <= rise_d;
            if (rise) begin
                r_dir <= q2;
                pos   <= q2 ? pos + POS_W'(1) : pos - POS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Testbench for rotary_quad_decoder. A detent-level reference model works on
// the sequence of stable pin states and predicts every r_step: its cycle, its
// direction and the position that goes with it.
module tb_rotary_quad_decoder;

    localparam int D   = 4;
    localparam int PW  = 4;
    localparam int LAT = D + 5;    // cycles from the last pin change to the r_event rise

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rot_a = 1'b0;
    logic          rot_b = 1'b0;
    logic          r_event;
    logic          r_dir;
    logic          r_step;
    logic [PW-1:0] pos;

    rotary_quad_decoder #(.DEBOUNCE_CYCLES(D), .POS_W(PW)) dut (
        .clk     (clk),
        .rst     (rst),
        .rot_a   (rot_a),
        .rot_b   (rot_b),
        .r_event (r_event),
        .r_dir   (r_dir),
        .r_step  (r_step),
        .pos     (pos)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int            cyc;
        logic          dir_prev;
        logic          dir;
        logic [PW-1:0] p;
        logic          ev;
        logic          ev_prev;
    } obs_t;

    typedef struct {
        int            cyc;
        logic          dir;
        logic [PW-1:0] p;
    } exp_t;

    obs_t obs_q[$];
    exp_t exp_q[$];
    logic prev_dir = 1'b0;
    logic prev_ev  = 1'b0;

    // Monitor: record every r_step sample, along with the values seen one cycle earlier.
    always @(negedge clk) begin
        if (!rst && r_step) begin
            obs_q.push_back('{cyc, prev_dir, r_dir, pos, r_event, prev_ev});
        end
        prev_dir = r_dir;
        prev_ev  = r_event;
    end

    // Reference model state. Pins are written as {a, b}.
    logic [1:0]    m_pins;
    logic          m_q1;
    logic          m_q2;
    logic          m_armed;
    logic [PW-1:0] m_pos;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (got no finish, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic model_init(input logic [1:0] pins);
        m_pins  = pins;
        m_q1    = (pins == 2'b11);
        m_q2    = (pins == 2'b01);
        m_armed = !m_q1;
        m_pos   = '0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic model_step(input logic [1:0] pins, input int t);
        logic nq1;
        logic nq2;
        nq1 = (pins == 2'b11) ? 1'b1 : (pins == 2'b00) ? 1'b0 : m_q1;
        nq2 = (pins == 2'b01) ? 1'b1 : (pins == 2'b10) ? 1'b0 : m_q2;
        if (!m_q1 && nq1 && m_armed) begin
            m_pos = nq2 ? m_pos + 1 : m_pos - 1;
            exp_q.push_back('{t + LAT, nq2, m_pos});
        end
        m_q1   = nq1;
        m_q2   = nq2;
        if (!nq1) m_armed = 1'b1;
        m_pins = pins;
    endtask

    task automatic do_reset(input logic [1:0] pins);
        @(negedge clk);
        rst = 1'b1;
        {rot_a, rot_b} = pins;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_init(pins);
        repeat (20) @(negedge clk);
    endtask

    // Move the pins to target, with optional chatter, hold them, then check the settled r_event.
    task automatic apply(input string name, input logic [1:0] target, input bit chatter, input int hold);
        logic [1:0] old;
        logic [1:0] diff;
        int t;
        old  = m_pins;
        diff = target ^ old;
        if (chatter && diff != 2'b00) begin
            repeat ($urandom_range(1, 3)) begin
                {rot_a, rot_b} = target;
                repeat ($urandom_range(1, D - 1)) @(negedge clk);
                {rot_a, rot_b} = old;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        {rot_a, rot_b} = target;
        t = cyc;
        model_step(target, t);
        repeat (hold) @(negedge clk);
        tests++;
        if (r_event !== (m_q1 & m_armed)) begin
            fails++;
            $display("FAIL %s r_event after pins=%b: got %b want %b", name, target, r_event, m_q1 & m_armed);
        end
    endtask

    // Compare every observed step against the model's list, then clear both.
    task automatic drain(input string name);
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s step count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].dir !== exp_q[i].dir ||
                obs_q[i].dir_prev !== exp_q[i].dir || obs_q[i].p !== exp_q[i].p ||
                obs_q[i].ev !== 1'b1 || obs_q[i].ev_prev !== 1'b0) begin
                fails++;
                $display("FAIL %s step %0d: got cyc=%0d dir=%b dir_prev=%b pos=%h ev=%b ev_prev=%b want cyc=%0d dir=%b pos=%h ev=1 ev_prev=0",
                         name, i, obs_q[i].cyc, obs_q[i].dir, obs_q[i].dir_prev, obs_q[i].p,
                         obs_q[i].ev, obs_q[i].ev_prev, exp_q[i].cyc, exp_q[i].dir, exp_q[i].p);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {rot_a, rot_b} = 2'b00;
        repeat (3) @(negedge clk);
        tests++;
        if ({r_event, r_dir, r_step, pos} !== '0) begin
            fails++;
            $display("FAIL reset_hold outputs: got ev=%b dir=%b step=%b pos=%h want all 0", r_event, r_dir, r_step, pos);
        end
        rst = 1'b0;
        model_init(2'b00);
        repeat (20) @(negedge clk);
        tests++;
        if ({r_event, r_dir, r_step, pos} !== '0) begin
            fails++;
            $display("FAIL reset_release outputs: got ev=%b dir=%b step=%b pos=%h want all 0", r_event, r_dir, r_step, pos);
        end
        drain("reset");
    endtask

    task automatic test_b_leads();
        do_reset(2'b00);
        apply("b_leads", 2'b01, 1'b0, 10);
        apply("b_leads", 2'b11, 1'b0, 10);
        tests++;
        if (pos !== 4'h1 || r_dir !== 1'b1) begin
            fails++;
            $display("FAIL b_leads detent: got pos=%h dir=%b want pos=1 dir=1", pos, r_dir);
        end
        apply("b_leads_ret", 2'b10, 1'b0, 10);
        apply("b_leads_ret", 2'b00, 1'b0, 10);
        tests++;
        if (pos !== 4'h1) begin
            fails++;
            $display("FAIL b_leads return pos: got %h want 1", pos);
        end
        drain("b_leads");
    endtask

    task automatic test_a_leads();
        do_reset(2'b00);
        apply("a_leads", 2'b10, 1'b0, 10);
        apply("a_leads", 2'b11, 1'b0, 10);
        tests++;
        if (pos !== 4'hF || r_dir !== 1'b0) begin
            fails++;
            $display("FAIL a_leads wrap: got pos=%h dir=%b want pos=f dir=0", pos, r_dir);
        end
        apply("a_leads", 2'b01, 1'b0, 10);
        apply("a_leads", 2'b00, 1'b0, 10);
        apply("a_leads", 2'b10, 1'b0, 10);
        apply("a_leads", 2'b11, 1'b0, 10);
        tests++;
        if (pos !== 4'hE || r_dir !== 1'b0) begin
            fails++;
            $display("FAIL a_leads repeat: got pos=%h dir=%b want pos=e dir=0", pos, r_dir);
        end
        apply("a_leads", 2'b10, 1'b0, 10);
        apply("a_leads", 2'b00, 1'b0, 10);
        drain("a_leads");
    endtask

    task automatic test_bounce();
        do_reset(2'b00);
        apply("bounce", 2'b01, 1'b0, 12);
        apply("bounce", 2'b11, 1'b1, 12);
        apply("bounce", 2'b01, 1'b1, 12);
        apply("bounce", 2'b00, 1'b1, 12);
        drain("bounce");
    endtask

    task automatic test_reset_at_11();
        do_reset(2'b11);
        tests++;
        if (r_event !== 1'b0 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL reset_at_11 idle: got ev=%b steps=%0d want ev=0 steps=0", r_event, obs_q.size());
        end
        apply("reset_at_11", 2'b00, 1'b0, 10);
        apply("reset_at_11", 2'b01, 1'b0, 10);
        apply("reset_at_11", 2'b11, 1'b0, 10);
        tests++;
        if (pos !== 4'h1 || r_dir !== 1'b1) begin
            fails++;
            $display("FAIL reset_at_11 first detent: got pos=%h dir=%b want pos=1 dir=1", pos, r_dir);
        end
        drain("reset_at_11");
    endtask

    task automatic test_partial();
        do_reset(2'b00);
        apply("partial", 2'b01, 1'b0, 10);
        apply("partial", 2'b00, 1'b0, 10);
        apply("partial", 2'b10, 1'b1, 10);
        apply("partial", 2'b00, 1'b1, 10);
        tests++;
        if (pos !== 4'h0 || r_event !== 1'b0) begin
            fails++;
            $display("FAIL partial: got pos=%h ev=%b want pos=0 ev=0", pos, r_event);
        end
        drain("partial");
    endtask

    task automatic test_async_reset();
        do_reset(2'b00);
        apply("async_rst", 2'b01, 1'b0, 10);
        {rot_a, rot_b} = 2'b11;
        repeat (D + 4) @(negedge clk);
        tests++;
        if (r_dir !== 1'b1 || r_event !== 1'b0 || pos !== 4'h1) begin
            fails++;
            $display("FAIL async_rst pre: got dir=%b ev=%b pos=%h want dir=1 ev=0 pos=1", r_dir, r_event, pos);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({r_event, r_dir, r_step, pos} !== '0) begin
            fails++;
            $display("FAIL async_rst immediate: got ev=%b dir=%b step=%b pos=%h want all 0", r_event, r_dir, r_step, pos);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_init(2'b11);
        repeat (20) @(negedge clk);
        tests++;
        if ({r_event, r_dir, r_step, pos} !== '0 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL async_rst after: got ev=%b dir=%b pos=%h steps=%0d want all 0", r_event, r_dir, pos, obs_q.size());
        end
        drain("async_rst");
    endtask

    task automatic test_random();
        logic [1:0] nxt;
        int r;
        do_reset(2'b00);
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      nxt = m_pins ^ 2'b01;
            else if (r < 80) nxt = m_pins ^ 2'b10;
            else             nxt = m_pins ^ 2'b11;
            apply("random", nxt, $urandom_range(0, 1) == 1, $urandom_range(10, 14));
        end
        if (m_pins != 2'b00) apply("random", 2'b00, 1'b0, 12);
        tests++;
        if (pos !== m_pos) begin
            fails++;
            $display("FAIL random final pos: got %h want %h", pos, m_pos);
        end
        drain("random");
    endtask

    initial begin
        model_init(2'b00);
        test_reset();
        test_b_leads();
        test_a_leads();
        test_bounce();
        test_reset_at_11();
        test_partial();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
